// File: rtl/mem_interface_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_interface_pkg
// Description : Shared definitions for the memory-access unit: default
//               parameter values, FSM state encoding and op encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_interface_pkg;

    localparam int ADDR_W_DEF  = 9;
    localparam int DATA_W_DEF  = 32;
    localparam int TIMEOUT_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FIN  = 2'd2
    } state_t;

    // Value carried on mem_we
    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

endpackage : mem_interface_pkg
`default_nettype wire

// File: rtl/mem_interface_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_interface_if
// Description : RAM-side req/ack bus of the memory-access unit.
//   mem_addr  : RAM word address              (master -> slave)
//   mem_wdata : RAM write data                (master -> slave)
//   mem_req   : request, held until ack       (master -> slave)
//   mem_we    : 1 = write, 0 = read           (master -> slave)
//   mem_ack   : completion; read data valid   (slave  -> master)
//   mem_rdata : RAM read data                 (slave  -> master)
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_interface_if
    import mem_interface_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_req;
    logic              mem_we;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_addr, mem_wdata, mem_req, mem_we,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_req, mem_we,
        output mem_ack, mem_rdata
    );
endinterface : mem_interface_if
`default_nettype wire

// File: rtl/mem_interface_timeout_ctr.sv
`default_nettype none
// ============================================================================
// Module      : mem_timeout_ctr
// Description : Ack-wait counter for the memory-access unit. Cleared by start,
//               advances on every en cycle; expired flags the en cycle in
//               which the count has reached TIMEOUT-1.
//   clk     : system clock
//   clear   : asynchronous active-low reset
//   start   : clear the count (request accepted)
//   en      : a REQ cycle without ack
//   expired : combinational, en && count == TIMEOUT-1
// Revision    : 1.0 - initial release
// ============================================================================
module mem_timeout_ctr #(
    parameter int TIMEOUT = 16
) (
    input  wire logic clk,
    input  wire logic clear,
    input  wire logic start,
    input  wire logic en,
    output logic      expired
);
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_count;

    assign expired = en && (r_count == C_LAST);

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            r_count <= '0;
        end else if (start) begin
            r_count <= '0;
        end else if (en && !expired) begin
            r_count <= r_count + 1'b1;
        end
    end
endmodule : mem_timeout_ctr
`default_nettype wire

// File: rtl/mem_interface.sv
`default_nettype none
// ============================================================================
// Module      : mem_interface
// Description : Multi-cycle memory-access unit between MAR/MDR and a
//               word-addressed RAM. Single-cycle read/write strobes start a
//               req/ack access; done pulses on completion, busy stalls the
//               sequencer. Optional ack timeout under macro MEM_TIMEOUT_EN.
//   clk, clear     : clock, asynchronous active-low reset
//   read, write    : request strobes (read wins if both high)
//   addr, wdata    : address from MAR (low ADDR_W bits used), data from MDR
//   Mdatain        : last completed read value
//   busy/done/err  : not-IDLE, completion pulse, timeout pulse
//   mem            : RAM req/ack bus (master side)
// Revision    : 1.0 - initial release
// ============================================================================
module mem_interface
    import mem_interface_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  wire logic              clk,
    input  wire logic              clear,
    input  wire logic              read,
    input  wire logic              write,
    input  wire logic [31:0]       addr,
    input  wire logic [DATA_W-1:0] wdata,
    output logic      [DATA_W-1:0] Mdatain,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    mem_interface_if.master        mem
);
    state_t r_state;
    state_t w_next_state;
    logic   w_accept;
    logic   w_expired;
    logic   w_req_out;

    assign w_accept = (r_state == IDLE) && (read || write);

`ifdef MEM_TIMEOUT_EN
    logic r_err;

    mem_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_ctr (
        .clk     (clk),
        .clear   (clear),
        .start   (w_accept),
        .en      ((r_state == REQ) && !mem.mem_ack),
        .expired (w_expired)
    );

    // err marks the FIN cycle reached by timeout rather than by ack
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            r_err <= 1'b0;
        end else begin
            r_err <= (r_state == REQ) && w_expired;
        end
    end

    assign err = r_err;

    logic w_unused;
    assign w_unused = ^addr[31:ADDR_W];
`else
    assign w_expired = 1'b0;
    assign err       = 1'b0;

    logic w_unused;
    assign w_unused = ^{addr[31:ADDR_W], (TIMEOUT > 0)};
`endif

    // State register
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and state-decoded outputs
    always_comb begin
        w_next_state = r_state;
        busy         = 1'b1;
        done         = 1'b0;
        w_req_out    = 1'b0;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (read || write) begin
                    w_next_state = REQ;
                end
            end
            REQ: begin
                w_req_out = 1'b1;
                // ack takes priority over an expiring count
                if (mem.mem_ack || w_expired) begin
                    w_next_state = FIN;
                end
            end
            FIN: begin
                done         = 1'b1;
                w_next_state = IDLE;
            end
            default: begin
                busy         = 1'b0;
                w_next_state = IDLE;
            end
        endcase
    end

    assign mem.mem_req = w_req_out;

    // Address/data/op are captured once at acceptance and held for the access
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
            mem.mem_we    <= OP_READ;
        end else if (w_accept) begin
            mem.mem_addr  <= addr[ADDR_W-1:0];
            mem.mem_wdata <= wdata;
            mem.mem_we    <= read ? OP_READ : OP_WRITE;
        end
    end

    // Only an acknowledged read updates the returned data
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            Mdatain <= '0;
        end else if ((r_state == REQ) && mem.mem_ack && (mem.mem_we == OP_READ)) begin
            Mdatain <= mem.mem_rdata;
        end
    end
endmodule : mem_interface
`default_nettype wire

// File: tb/tb_mem_interface.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_interface
// Description : Self-checking bench for mem_interface with a behavioural RAM
//               whose ack delay is programmable.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_interface;
    import mem_interface_pkg::*;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 32;
    localparam int BUDGET = 100;

    logic              clk = 1'b0;
    logic              clear = 1'b0;
    logic              read = 1'b0;
    logic              write = 1'b0;
    logic [31:0]       addr = '0;
    logic [DATA_W-1:0] wdata = '0;
    logic [DATA_W-1:0] Mdatain;
    logic              busy, done, err;

    int vectors = 0;
    int miscompares = 0;
    logic [DATA_W-1:0] exp_q[$];

    mem_interface_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_interface #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(16)) dut (
        .clk     (clk),
        .clear   (clear),
        .read    (read),
        .write   (write),
        .addr    (addr),
        .wdata   (wdata),
        .Mdatain (Mdatain),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .mem     (bus)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural RAM ----------------
    logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];
    int                ack_delay = 0;
    bit                ack_never = 1'b0;
    logic              ack_force = 1'b0;
    int                wait_cnt = 0;
    int                ack_count = 0;
    logic              model_ack;
    logic              pre_en = 1'b0;
    logic [ADDR_W-1:0] pre_addr = '0;
    logic [DATA_W-1:0] pre_data = '0;

    assign model_ack     = bus.mem_req && !ack_never && (wait_cnt == ack_delay);
    assign bus.mem_ack   = model_ack || ack_force;
    assign bus.mem_rdata = ram[bus.mem_addr];

    always @(posedge clk) begin
        if (!bus.mem_req || model_ack) wait_cnt <= 0;
        else                           wait_cnt <= wait_cnt + 1;
        if (bus.mem_req && bus.mem_ack) begin
            ack_count <= ack_count + 1;
            if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
        end
        if (pre_en) ram[pre_addr] <= pre_data;
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        pre_addr = a;
        pre_data = d;
        pre_en   = 1'b1;
        tick();
        pre_en   = 1'b0;
    endtask

    task automatic strobe(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [DATA_W-1:0] d);
        read  = rd;
        write = wr;
        addr  = a;
        wdata = d;
        tick();
        read  = 1'b0;
        write = 1'b0;
    endtask

    // Called right after strobe(); cycles counts edges from the strobe edge.
    task automatic wait_done(output int cycles, output int busy_cycles,
                             output int req_cycles, output bit timed_out);
        cycles = 1; busy_cycles = 0; req_cycles = 0; timed_out = 1'b0;
        forever begin
            if (busy) busy_cycles++;
            if (bus.mem_req) req_cycles++;
            if (done) break;
            if (cycles >= BUDGET) begin
                timed_out = 1'b1;
                break;
            end
            tick();
            cycles++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int c, b, r; bit to;
        int done_seen;
        clear = 1'b0;
        tick(); tick();
        vectors++;
        if ({busy, done, err, bus.mem_req, bus.mem_we} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: busy/done/err/req/we=%b required 00000",
                     {busy, done, err, bus.mem_req, bus.mem_we});
        end
        vectors++;
        if ({Mdatain, bus.mem_addr, bus.mem_wdata} !== '0) begin
            miscompares++;
            $display("FAIL reset_data: Mdatain=%h mem_addr=%h mem_wdata=%h required 0",
                     Mdatain, bus.mem_addr, bus.mem_wdata);
        end
        clear = 1'b1;
        tick();
        preload(9'h005, 32'h0BAD_F00D);
        ack_never = 1'b1;
        strobe(1'b1, 1'b0, 32'h5, 32'h0);
        tick();
        vectors++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== 9'h005) begin
            miscompares++;
            $display("FAIL reset_pre_req: req=%b addr=%h required 1/005", bus.mem_req, bus.mem_addr);
        end
        @(negedge clk);
        clear = 1'b0;
        #1;
        vectors++;
        if (bus.mem_req !== 1'b0 || busy !== 1'b0 || Mdatain !== '0) begin
            miscompares++;
            $display("FAIL reset_mid_req: req=%b busy=%b Mdatain=%h required 0/0/0",
                     bus.mem_req, busy, Mdatain);
        end
        tick();
        clear = 1'b1;
        ack_never = 1'b0;
        ack_force = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            ack_force = 1'b0;
            if (done || busy) done_seen++;
        end
        vectors++;
        if (done_seen != 0 || Mdatain !== '0) begin
            miscompares++;
            $display("FAIL reset_late_ack: done/busy cycles=%0d Mdatain=%h required 0/0",
                     done_seen, Mdatain);
        end
        c = 0; b = 0; r = 0; to = 0;
    endtask

    task automatic test_write_read();
        int c, b, r; bit to;
        logic [DATA_W-1:0] e;
        ack_delay = 0;
        strobe(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF);
        wait_done(c, b, r, to);
        vectors++;
        if (to || c != 2 || b != 2 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL write_latency: cycles=%0d busy=%0d err=%b required 2/2/0", c, b, err);
        end
        tick();
        vectors++;
        if (busy !== 1'b0 || ram[9'h010] !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("FAIL write_data: busy=%b ram[10]=%h required 0/deadbeef", busy, ram[9'h010]);
        end
        exp_q.push_back(32'hDEAD_BEEF);
        strobe(1'b1, 1'b0, 32'h10, 32'h0);
        wait_done(c, b, r, to);
        e = exp_q.pop_front();
        vectors++;
        if (to || c != 2 || b != 2 || Mdatain !== e) begin
            miscompares++;
            $display("FAIL read_back: cycles=%0d busy=%0d Mdatain=%h required 2/2/%h", c, b, Mdatain, e);
        end
        tick();
    endtask

    task automatic test_ack_delay();
        int c, b, r; bit to;
        bit stable_ok;
        logic [DATA_W-1:0] e;
        preload(9'h1FF, 32'hCAFE_F00D);
        ack_delay = 5;
        exp_q.push_back(32'hCAFE_F00D);
        strobe(1'b1, 1'b0, 32'h1FF, 32'h0);
        stable_ok = 1'b1;
        c = 1; r = 0; to = 1'b0;
        while (!done && c < BUDGET) begin
            if (bus.mem_req) begin
                r++;
                if (bus.mem_addr !== 9'h1FF || Mdatain !== 32'hDEAD_BEEF) stable_ok = 1'b0;
            end
            tick();
            c++;
        end
        to = !done;
        vectors++;
        if (to || r != 6 || c != 7) begin
            miscompares++;
            $display("FAIL delay_timing: req cycles=%0d done cycle=%0d required 6/7", r, c);
        end
        vectors++;
        if (!stable_ok) begin
            miscompares++;
            $display("FAIL delay_stable: addr/Mdatain changed during REQ, got 0 required 1");
        end
        e = exp_q.pop_front();
        vectors++;
        if (Mdatain !== e) begin
            miscompares++;
            $display("FAIL delay_data: Mdatain=%h required %h", Mdatain, e);
        end
        tick();
        b = 0;
    endtask

    task automatic test_wrap_dual();
        int start_acks, dones;
        logic [DATA_W-1:0] e, got;
        preload(9'h003, 32'h3333_3333);
        ack_delay = 2;
        start_acks = ack_count;
        exp_q.push_back(32'h3333_3333);
        strobe(1'b1, 1'b1, 32'h0000_0203, 32'h9999_9999);
        vectors++;
        if (bus.mem_addr !== 9'h003 || bus.mem_we !== 1'b0) begin
            miscompares++;
            $display("FAIL wrap_addr: mem_addr=%h we=%b required 003/0", bus.mem_addr, bus.mem_we);
        end
        strobe(1'b0, 1'b1, 32'h0000_0044, 32'h7777_7777);
        dones = 0; got = '0;
        for (int i = 0; i < 10; i++) begin
            if (done) begin
                dones++;
                got = Mdatain;
            end
            tick();
        end
        e = exp_q.pop_front();
        vectors++;
        if (dones != 1 || (ack_count - start_acks) != 1) begin
            miscompares++;
            $display("FAIL busy_ignore: dones=%0d accesses=%0d required 1/1", dones, ack_count - start_acks);
        end
        vectors++;
        if (got !== e || ram[9'h003] !== 32'h3333_3333) begin
            miscompares++;
            $display("FAIL dual_strobe: Mdatain=%h ram[3]=%h required %h/33333333", got, ram[9'h003], e);
        end
    endtask

    task automatic test_write_preserves();
        int c, b, r; bit to;
        logic [DATA_W-1:0] e;
        preload(9'h020, 32'h1234_5678);
        ack_delay = 1;
        exp_q.push_back(32'h1234_5678);
        strobe(1'b1, 1'b0, 32'h20, 32'h0);
        wait_done(c, b, r, to);
        e = exp_q.pop_front();
        vectors++;
        if (to || Mdatain !== e) begin
            miscompares++;
            $display("FAIL preserve_read: Mdatain=%h required %h", Mdatain, e);
        end
        tick();
        strobe(1'b0, 1'b1, 32'h21, 32'hAAAA_5555);
        wait_done(c, b, r, to);
        tick();
        vectors++;
        if (to || Mdatain !== 32'h1234_5678 || ram[9'h021] !== 32'hAAAA_5555) begin
            miscompares++;
            $display("FAIL preserve_write: Mdatain=%h ram[21]=%h required 12345678/aaaa5555",
                     Mdatain, ram[9'h021]);
        end
    endtask

`ifdef MEM_TIMEOUT_EN
    task automatic test_timeout();
        int c, b, r; bit to;
        int dones;
        logic [DATA_W-1:0] e;
        ack_never = 1'b1;
        strobe(1'b1, 1'b0, 32'h30, 32'h0);
        wait_done(c, b, r, to);
        vectors++;
        if (to || c != 17 || err !== 1'b1 || bus.mem_req !== 1'b0 || Mdatain !== 32'h1234_5678) begin
            miscompares++;
            $display("FAIL timeout_err: cycle=%0d err=%b req=%b Mdatain=%h required 17/1/0/12345678",
                     c, err, bus.mem_req, Mdatain);
        end
        tick();
        ack_never = 1'b0;
        ack_force = 1'b1;
        dones = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            ack_force = 1'b0;
            if (done || err) dones++;
        end
        vectors++;
        if (dones != 0 || Mdatain !== 32'h1234_5678) begin
            miscompares++;
            $display("FAIL timeout_stray: done/err cycles=%0d Mdatain=%h required 0/12345678", dones, Mdatain);
        end
        preload(9'h031, 32'h5A5A_5A5A);
        ack_delay = 15;
        exp_q.push_back(32'h5A5A_5A5A);
        strobe(1'b1, 1'b0, 32'h31, 32'h0);
        wait_done(c, b, r, to);
        e = exp_q.pop_front();
        vectors++;
        if (to || c != 17 || err !== 1'b0 || Mdatain !== e) begin
            miscompares++;
            $display("FAIL timeout_last_ack: cycle=%0d err=%b Mdatain=%h required 17/0/%h", c, err, Mdatain, e);
        end
        tick();
    endtask
`else
    task automatic test_no_timeout();
        int c, b, r; bit to;
        logic [DATA_W-1:0] e;
        preload(9'h031, 32'h5A5A_5A5A);
        ack_delay = 20;
        exp_q.push_back(32'h5A5A_5A5A);
        strobe(1'b1, 1'b0, 32'h31, 32'h0);
        wait_done(c, b, r, to);
        e = exp_q.pop_front();
        vectors++;
        if (to || c != 22 || r != 21 || err !== 1'b0 || Mdatain !== e) begin
            miscompares++;
            $display("FAIL long_wait: cycle=%0d req=%0d err=%b Mdatain=%h required 22/21/0/%h",
                     c, r, err, Mdatain, e);
        end
        tick();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_read();
        test_ack_delay();
        test_wrap_dual();
        test_write_preserves();
`ifdef MEM_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule : tb_mem_interface
`default_nettype wire
